// File: rtl/keypad_emulator.sv
// Emulates one key of a 4x4 active-low matrix keypad: plays a requested key out
// as press bounce, hold, release bounce and gap, and returns rows for the driven column.
`timescale 1ns/1ps

module keypad_emulator #(
   parameter int CYCLES_PER_MS = 100_000,
   parameter int HOLD_MS       = 50,
   parameter int GAP_MS        = 10,
   parameter int BOUNCE_CYCLES = 2000
) (
   input  logic       clk_100MHz,
   input  logic       reset_n,
   input  logic [3:0] col,
   output logic [3:0] row,
   input  logic [3:0] key_code,
   input  logic       key_valid,
   output logic       key_ready,
   output logic       pressed,
   output logic       done
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      BOUNCE_P = 3'd1,
      HOLD     = 3'd2,
      BOUNCE_R = 3'd3,
      GAP      = 3'd4
   } state_t;

   localparam bit          HAS_BOUNCE  = (BOUNCE_CYCLES != 0);
   localparam logic [31:0] BOUNCE_LAST = HAS_BOUNCE ? 32'(BOUNCE_CYCLES - 1) : 32'd0;
   localparam logic [31:0] HOLD_LAST   = 32'(HOLD_MS * CYCLES_PER_MS - 1);
   localparam logic [31:0] GAP_LAST    = 32'(GAP_MS * CYCLES_PER_MS - 1);
   localparam logic [15:0] LFSR_SEED   = 16'hACE1;

   state_t      state;
   logic [31:0] cnt;
   logic [15:0] lfsr;
   logic [15:0] lfsr_nxt;
   logic [3:0]  key_q;
   logic [3:0]  col_s1;
   logic [3:0]  col_s2;
   logic [1:0]  key_c;
   logic [1:0]  key_r;
   logic [3:0]  row_nxt;

   // Fibonacci taps 16,14,13,11 map to bits 15,13,12,10
   assign lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         cnt       <= 32'd0;
         lfsr      <= LFSR_SEED;
         key_q     <= 4'd0;
         pressed   <= 1'b0;
         done      <= 1'b0;
         key_ready <= 1'b1;
      end else begin
         done <= 1'b0;
         cnt  <= cnt + 32'd1;
         case (state)
            IDLE: begin
               pressed <= 1'b0;
               cnt     <= 32'd0;
               if (key_valid && key_ready) begin
                  key_q     <= key_code;
                  key_ready <= 1'b0;
                  state     <= HAS_BOUNCE ? BOUNCE_P : HOLD;
               end
            end
            BOUNCE_P: begin
               pressed <= lfsr[0];
               lfsr    <= lfsr_nxt;
               if (cnt == BOUNCE_LAST) begin
                  cnt   <= 32'd0;
                  state <= HOLD;
               end
            end
            HOLD: begin
               pressed <= 1'b1;
               if (cnt == HOLD_LAST) begin
                  cnt   <= 32'd0;
                  state <= HAS_BOUNCE ? BOUNCE_R : GAP;
               end
            end
            BOUNCE_R: begin
               pressed <= lfsr[0];
               lfsr    <= lfsr_nxt;
               if (cnt == BOUNCE_LAST) begin
                  cnt   <= 32'd0;
                  state <= GAP;
               end
            end
            GAP: begin
               pressed <= 1'b0;
               if (cnt == GAP_LAST) begin
                  cnt       <= 32'd0;
                  state     <= IDLE;
                  key_ready <= 1'b1;
                  done      <= 1'b1;
               end
            end
            default: begin
               pressed   <= 1'b0;
               cnt       <= 32'd0;
               key_ready <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

   // Column/row position of the latched key in the matrix
   always_comb begin
      key_c = 2'd0;
      key_r = 2'd0;
      case (key_q)
         4'h1: begin key_c = 2'd0; key_r = 2'd0; end
         4'h4: begin key_c = 2'd0; key_r = 2'd1; end
         4'h7: begin key_c = 2'd0; key_r = 2'd2; end
         4'h0: begin key_c = 2'd0; key_r = 2'd3; end
         4'h2: begin key_c = 2'd1; key_r = 2'd0; end
         4'h5: begin key_c = 2'd1; key_r = 2'd1; end
         4'h8: begin key_c = 2'd1; key_r = 2'd2; end
         4'hF: begin key_c = 2'd1; key_r = 2'd3; end
         4'h3: begin key_c = 2'd2; key_r = 2'd0; end
         4'h6: begin key_c = 2'd2; key_r = 2'd1; end
         4'h9: begin key_c = 2'd2; key_r = 2'd2; end
         4'hE: begin key_c = 2'd2; key_r = 2'd3; end
         4'hA: begin key_c = 2'd3; key_r = 2'd0; end
         4'hB: begin key_c = 2'd3; key_r = 2'd1; end
         4'hC: begin key_c = 2'd3; key_r = 2'd2; end
         4'hD: begin key_c = 2'd3; key_r = 2'd3; end
         default: begin key_c = 2'd0; key_r = 2'd0; end
      endcase
   end

   // Only the key's own column matters; other driven columns see an open contact
   always_comb begin
      row_nxt = 4'b1111;
      if (pressed && !col_s2[2'd3 - key_c])
         row_nxt[2'd3 - key_r] = 1'b0;
   end

   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         col_s1 <= 4'b1111;
         col_s2 <= 4'b1111;
         row    <= 4'b1111;
      end else begin
         col_s1 <= col;
         col_s2 <= col_s1;
         row    <= row_nxt;
      end
   end

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator: a no-bounce instance for timing, mapping,
// handshake and reset, and a bounce instance for the LFSR contact pattern.
`timescale 1ns/1ps

module tb_keypad_emulator;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [3:0] col, row, key_code;
   logic       key_valid, key_ready, pressed, done;
   logic [3:0] col_b, row_b, key_code_b;
   logic       key_valid_b, key_ready_b, pressed_b, done_b;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   keypad_emulator #(.CYCLES_PER_MS(10), .HOLD_MS(3), .GAP_MS(2), .BOUNCE_CYCLES(0)) u_dut (
      .clk_100MHz(clk), .reset_n(reset_n), .col(col), .row(row),
      .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
      .pressed(pressed), .done(done));

   keypad_emulator #(.CYCLES_PER_MS(10), .HOLD_MS(3), .GAP_MS(2), .BOUNCE_CYCLES(8)) u_bnc (
      .clk_100MHz(clk), .reset_n(reset_n), .col(col_b), .row(row_b),
      .key_code(key_code_b), .key_valid(key_valid_b), .key_ready(key_ready_b),
      .pressed(pressed_b), .done(done_b));

   // Hand-derived key map: column drive that selects each key and its row answer
   logic [3:0] exp_col [16] = '{4'b0111, 4'b0111, 4'b1011, 4'b1101, 4'b0111, 4'b1011, 4'b1101, 4'b0111,
                                4'b1011, 4'b1101, 4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b1101, 4'b1011};
   logic [3:0] exp_row [16] = '{4'b1110, 4'b0111, 4'b0111, 4'b0111, 4'b1011, 4'b1011, 4'b1011, 4'b1101,
                                4'b1101, 4'b1101, 4'b0111, 4'b1011, 4'b1101, 4'b1110, 4'b1110, 4'b1110};
   logic [3:0] col_pat [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic press(input logic [3:0] k);
      key_code  = k;
      key_valid = 1'b1;
      @(posedge clk); #1;
      key_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (key_ready !== 1'b1 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 200) chk(tag, {31'd0, key_ready}, 1);
      @(posedge clk); #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      logic [7:0] bp;
      logic [7:0] br;
      logic       bad;
      logic [3:0] er;
      reset_n = 1'b0; col = 4'b1111; key_code = 4'd0; key_valid = 1'b0;
      col_b = 4'b1111; key_code_b = 4'd0; key_valid_b = 1'b0;
      repeat (3) @(posedge clk); #1;
      chk("rst row", row, 4'b1111);
      chk("rst ready", key_ready, 1);
      chk("rst pressed", pressed, 0);
      chk("rst done", done, 0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      // Key 5 with its column held: 30 cycles of row 1011, done seen by edge T+51
      col = 4'b1011;
      press(4'h5);
      chk("t1 ready j0", key_ready, 0);
      for (int j = 1; j <= 55; j++) begin
         @(posedge clk); #1;
         chk($sformatf("t1 row j=%0d", j), row, (j >= 2 && j <= 31) ? 4'b1011 : 4'b1111);
         chk($sformatf("t1 pressed j=%0d", j), pressed, (j >= 1 && j <= 30) ? 1 : 0);
         chk($sformatf("t1 done j=%0d", j), done, (j == 50) ? 1 : 0);
         chk($sformatf("t1 ready j=%0d", j), key_ready, (j >= 50) ? 1 : 0);
      end

      // Rotating columns: only the 1011 window answers, 3 cycles late
      col = 4'b0111;
      press(4'h5);
      for (int j = 1; j <= 52; j++) begin
         @(posedge clk); #1;
         chk($sformatf("t2 row j=%0d", j), row, (j >= 15 && j <= 26) ? 4'b1011 : 4'b1111);
         if (j == 50) chk("t2 done", done, 1);
         if (j == 12) col = 4'b1011;
         if (j == 24) col = 4'b1101;
         if (j == 36) col = 4'b1110;
      end
      wait_idle("t2 idle timeout");

      // Every key against every column
      for (int k = 0; k < 16; k++) begin
         col = 4'b1111;
         press(4'(k));
         @(posedge clk); #1;
         for (int c = 0; c < 4; c++) begin
            col = col_pat[c];
            repeat (4) @(posedge clk);
            #1;
            er = (col_pat[c] == exp_col[k]) ? exp_row[k] : 4'b1111;
            chk($sformatf("t3 key=%0h col=%b row", k, col_pat[c]), row, er);
         end
         col = 4'b1111;
         wait_idle($sformatf("t3 key=%0h idle timeout", k));
      end

      // key_valid held: 3 runs to completion, 9 is taken only in the done cycle
      col = 4'b1101;
      key_code = 4'h3; key_valid = 1'b1;
      @(posedge clk); #1;
      key_code = 4'h9;
      chk("t4 ready after accept", key_ready, 0);
      bad = 1'b0;
      for (int j = 1; j <= 60; j++) begin
         @(posedge clk); #1;
         if (j < 50 && key_ready) bad = 1'b1;
         if (j == 10) chk("t4 first key row", row, 4'b0111);
         if (j == 50) begin
            chk("t4 done", done, 1);
            chk("t4 ready in done", key_ready, 1);
         end
         if (j == 51) begin
            chk("t4 second accepted", key_ready, 0);
            key_valid = 1'b0;
         end
         if (j == 60) chk("t4 second key row", row, 4'b1101);
      end
      chk("t4 no early ready", bad, 0);
      wait_idle("t4 idle timeout");

      // Asynchronous reset 5 cycles into HOLD
      col = 4'b1011;
      press(4'h5);
      repeat (5) @(posedge clk);
      #2;
      chk("t5 pressed before rst", pressed, 1);
      reset_n = 1'b0;
      #1;
      chk("t5 rst row", row, 4'b1111);
      chk("t5 rst pressed", pressed, 0);
      chk("t5 rst ready", key_ready, 1);
      @(negedge clk);
      reset_n = 1'b1;
      bad = 1'b0;
      repeat (60) begin
         @(posedge clk); #1;
         if (done || !key_ready || row != 4'b1111) bad = 1'b1;
      end
      chk("t5 quiet after rst", bad, 0);

      // Bounce instance: LFSR bit0 from 0xACE1 is 1,1,1,1,0,0,1,0 then 0,0,1,0,1,0,1,0
      bp = 8'h4F;
      br = 8'h54;
      key_code_b = 4'h5; key_valid_b = 1'b1;
      @(posedge clk); #1;
      key_valid_b = 1'b0;
      for (int j = 1; j <= 70; j++) begin
         @(posedge clk); #1;
         if (j <= 8)       chk($sformatf("t6 bounce_p j=%0d", j), pressed_b, bp[j-1]);
         else if (j <= 38) chk($sformatf("t6 hold j=%0d", j), pressed_b, 1);
         else if (j <= 46) chk($sformatf("t6 bounce_r j=%0d", j), pressed_b, br[j-39]);
         else              chk($sformatf("t6 gap j=%0d", j), pressed_b, 0);
         chk($sformatf("t6 done j=%0d", j), done_b, (j == 66) ? 1 : 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/keypad_emulator.md
# keypad_emulator

Cycle-accurate stand-in for the 4x4 PMOD keypad: it observes the active-low column drive from the keypad scanner and returns the active-low row pattern a physical keypad would produce for one emulated key. Key presses are requested by a valid/ready handshake and played out as press-bounce, hold, release-bounce and inter-key gap, all timed in milliseconds. It sits on the keypad side of the col/row interface, either on the same die as the scanner for self-test or on a second board driving a PMOD port.

## Interface
- CYCLES_PER_MS, 100_000, clock cycles per millisecond.
- HOLD_MS, 50, contact-closed duration after press bounce, in ms (≥1).
- GAP_MS, 10, contact-open duration after release bounce, in ms (≥1).
- BOUNCE_CYCLES, 2000, duration of each bounce phase in cycles; 0 disables both bounce phases.
- clk_100MHz  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- col  in  4  column drive from scanner, active-low, treated as asynchronous.
- row  out  4  row return to scanner, active-low; reset 4'b1111.
- key_code  in  4  key value to press, 0x0–0xF.
- key_valid  in  1  request to press key_code.
- key_ready  out  1  high exactly while in IDLE; reset 1.
- pressed  out  1  current emulated contact state; reset 0.
- done  out  1  one-cycle pulse when a press sequence completes; reset 0.

## Operation
- Key map, as column c (active when col[3-c]=0) / row r (drives row[3-r]=0): c0: r0=1, r1=4, r2=7, r3=0; c1: 2, 5, 8, F; c2: 3, 6, 9, E; c3: A, B, C, D.
- col passes through a 2-flop synchronizer, reset value 4'b1111.
- row register: row[3-r] <= 0 iff pressed=1 and sync_col[3-c]=0 for the latched key; all other row bits are 1. Other column bits are ignored, matching the electrical behaviour of a matrix keypad. If pressed=0, row <= 4'b1111.
- Handshake: a press is accepted on the edge where key_valid & key_ready are both high. key_code is latched into a 4-bit register at acceptance. key_valid outside IDLE is ignored and not queued.
- FSM states: IDLE, BOUNCE_P, HOLD, BOUNCE_R, GAP.
  - IDLE -> BOUNCE_P on accept, or -> HOLD when BOUNCE_CYCLES=0.
  - BOUNCE_P runs BOUNCE_CYCLES cycles; pressed = lfsr[0].
  - HOLD runs HOLD_MS*CYCLES_PER_MS cycles; pressed = 1.
  - BOUNCE_R runs BOUNCE_CYCLES cycles, or is skipped when BOUNCE_CYCLES=0; pressed = lfsr[0].
  - GAP runs GAP_MS*CYCLES_PER_MS cycles; pressed = 0.
  - GAP -> IDLE.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1 on reset. It advances only in bounce states and is not reseeded between presses.
- Phase counter: 32-bit, cleared on every state entry. A phase ends when the counter equals length-1.
- done is registered high for the single cycle after the GAP->IDLE transition (the first IDLE cycle), coincident with key_ready=1.
- A request can be accepted in the same cycle that done is high.
- Reset asserted mid-sequence: all outputs and state return to reset values immediately. No completion pulse is issued, and the latched key is discarded.

## Timing
- pressed is a registered output of the state/LFSR. row follows pressed or a col change with 1 cycle of latency from pressed, and 3 cycles from a col edge (2 sync + 1 output register). The scanner's 10-cycle sample lag covers this.
- Accept at edge T: the state is BOUNCE_P (or HOLD) from T+1. pressed reflects the new state from T+1 or T+2, fixed by the registered output; both implementer and bench use T+2.
- Total sequence, accept to done: 2*BOUNCE_CYCLES + (HOLD_MS+GAP_MS)*CYCLES_PER_MS + 1 cycles.
- key_ready deasserts the cycle after accept and reasserts with done.

## Test plan
- Parameters CYCLES_PER_MS=10, HOLD_MS=3, GAP_MS=2, BOUNCE_CYCLES=0. Press key 5 with col held 4'b1011: row=4'b1011 for exactly 30 cycles, then 4'b1111. done fires 51 cycles after accept.
- Same parameters, key 5, col rotating 0111→1011→1101→1110 every 12 cycles during HOLD: row is 4'b1011 only in the 1011 window (3 cycles delayed), and 4'b1111 otherwise.
- All 16 codes, each column driven in turn: exactly one column/row pair produces a low row bit, matching the key map (e.g. F → col 1011, row 1110; A → col 1110, row 0111).
- key_valid held high continuously with codes 3 then 9: the second code is accepted only in the done cycle, and the code presented mid-sequence is ignored.
- Assert reset_n low 5 cycles into HOLD: row=1111, pressed=0, key_ready=1 asynchronously, and no done pulse follows.
- BOUNCE_CYCLES=8: pressed follows the LFSR sequence from 0xACE1 for 8 cycles, is stable 1 during HOLD, and toggles again in BOUNCE_R.
- Loopback with the scanner at default timing: its decoded output equals the pressed key_code for all 16 keys.
